// File: rtl/ledarb_pkg.sv
// Shared types for the LED ownership arbiter: FSM states and widths.
// No logic of its own.
// No flow control.
package ledarb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEASE = 2'd1,
    OPEN  = 2'd2
  } state_t;

  localparam int PWM_CNT_W = 8;
  localparam int IDX_W     = 3;
endpackage

// File: rtl/led_owner_arb_rr_pick.sv
// Round-robin picker: nearest requester after 'last', wrapping NREQ-1 to 0.
// Purely combinational, zero latency.
// No flow control; vld low when no request is present.
module rr_pick
  import ledarb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             vld
);

  int best;

  // Distance 0 is last+1, so the previous owner is considered last.
  always_comb begin
    winner = '0;
    vld    = 1'b0;
    best   = NREQ;
    for (int k = 0; k < NREQ; k++) begin
      if (req[k] && (((k + NREQ - int'(last) - 1) % NREQ) < best)) begin
        best   = (k + NREQ - int'(last) - 1) % NREQ;
        winner = IDX_W'(k);
        vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_owner_arb.sv
// LED bank ownership arbiter with minimum lease; LEDARB_PWM_EN adds duty-cycle dimming.
// Grant one cycle after request, o_led one cycle after the owner is seen.
// No backpressure: requests are levels, the owner releases by dropping its request.
module led_owner_arb
  import ledarb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NLEDS = 8,
  parameter int HOLDW = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*NLEDS-1:0] i_pattern,
  input  logic [NLEDS-1:0]      i_default,
  input  logic [HOLDW-1:0]      i_hold,
`ifdef LEDARB_PWM_EN
  input  logic [PWM_CNT_W-1:0]  i_duty,
`endif
  output logic [NREQ-1:0]       o_grant,
  output logic [IDX_W-1:0]      o_owner,
  output logic                  o_busy,
  output logic [NLEDS-1:0]      o_led
);

  localparam logic [HOLDW-1:0] CNT_ONE = HOLDW'(1);

  state_t            state;
  logic [HOLDW-1:0]  cnt;
  logic [IDX_W-1:0]  last_owner;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;
  logic              own_req;
  logic [NLEDS-1:0]  led_base;
  logic [NLEDS-1:0]  led_drv;

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) v[i] = (int'(idx) == i);
    return v;
  endfunction

  // Masking the current owner lets the same picker serve IDLE and OPEN handover.
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (i_req & ~o_grant),
    .last   (last_owner),
    .winner (pick_idx),
    .vld    (pick_vld)
  );

  assign own_req = |(i_req & o_grant);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      o_grant    <= '0;
      o_busy     <= 1'b0;
      o_owner    <= '0;
      cnt        <= '0;
      last_owner <= IDX_W'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            o_grant    <= onehot(pick_idx);
            o_owner    <= pick_idx;
            o_busy     <= 1'b1;
            last_owner <= pick_idx;
            cnt        <= i_hold;
            state      <= (i_hold == '0) ? OPEN : LEASE;
          end
        end
        LEASE: begin
          if (!own_req) begin
            o_grant <= '0;
            o_busy  <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
          end else if (cnt == CNT_ONE) begin
            cnt   <= '0;
            state <= OPEN;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        OPEN: begin
          // Owner release wins over a simultaneous handover request.
          if (!own_req) begin
            o_grant <= '0;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end else if (pick_vld) begin
            o_grant    <= onehot(pick_idx);
            o_owner    <= pick_idx;
            last_owner <= pick_idx;
            cnt        <= i_hold;
            state      <= (i_hold == '0) ? OPEN : LEASE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    led_base = i_default;
    for (int k = 0; k < NREQ; k++) begin
      if (o_grant[k]) led_base = i_pattern[k*NLEDS +: NLEDS];
    end
  end

`ifdef LEDARB_PWM_EN
  logic [PWM_CNT_W-1:0] pwm_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) pwm_cnt <= '0;
    else            pwm_cnt <= pwm_cnt + PWM_CNT_W'(1);
  end

  assign led_drv = led_base & {NLEDS{pwm_cnt < i_duty}};
`else
  assign led_drv = led_base;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) o_led <= '0;
    else            o_led <= led_drv;
  end

endmodule

// File: tb/tb_led_owner_arb.sv
// Random and directed stimulus for led_owner_arb against a lease/owner reference model.
module tb_led_owner_arb;
  localparam int NREQ  = 4;
  localparam int NLEDS = 8;
  localparam int HOLDW = 16;

  logic                  i_clk;
  logic                  i_reset_n;
  logic [NREQ-1:0]       i_req;
  logic [NREQ*NLEDS-1:0] i_pattern;
  logic [NLEDS-1:0]      i_default;
  logic [HOLDW-1:0]      i_hold;
`ifdef LEDARB_PWM_EN
  logic [7:0]            i_duty;
`endif
  logic [NREQ-1:0]       o_grant;
  logic [2:0]            o_owner;
  logic                  o_busy;
  logic [NLEDS-1:0]      o_led;

  led_owner_arb #(.NREQ(NREQ), .NLEDS(NLEDS), .HOLDW(HOLDW)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_req     (i_req),
    .i_pattern (i_pattern),
    .i_default (i_default),
    .i_hold    (i_hold),
`ifdef LEDARB_PWM_EN
    .i_duty    (i_duty),
`endif
    .o_grant   (o_grant),
    .o_owner   (o_owner),
    .o_busy    (o_busy),
    .o_led     (o_led)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: who owns the bank, lease cycles left, last granted index.
  int               m_owner;
  int               m_left;
  int               m_last;
  int               m_pwm;
  logic [NLEDS-1:0] m_led;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr(input logic [NREQ-1:0] req, input int last);
    for (int off = 1; off <= NREQ; off++) begin
      if (((req >> ((last + off) % NREQ)) & 1) != 0) return (last + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_left  = 0;
    m_last  = NREQ - 1;
    m_pwm   = 0;
    m_led   = '0;
  endtask

  task automatic grant_to(input int k);
    m_owner = k;
    m_last  = k;
    m_left  = int'(i_hold);
  endtask

  task automatic model_step();
    logic [NLEDS-1:0] led;
    logic [NREQ-1:0]  others;
    led = (m_owner >= 0) ? NLEDS'(i_pattern >> (m_owner * NLEDS)) : i_default;
`ifdef LEDARB_PWM_EN
    if (m_pwm >= int'(i_duty)) led = '0;
    m_pwm = (m_pwm + 1) % 256;
`endif
    m_led = led;
    if (m_owner < 0) begin
      if (i_req != '0) grant_to(rr(i_req, m_last));
    end else if (((i_req >> m_owner) & 1) == 0) begin
      m_owner = -1;
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      others = i_req & ~(NREQ'(1) << m_owner);
      if (others != '0) grant_to(rr(others, m_last));
    end
  endtask

  task automatic check_outputs();
    chk("grant", 32'(o_grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    chk("busy", 32'(o_busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    if (m_owner >= 0) chk("owner", 32'(o_owner), 32'(m_owner));
    chk("led", 32'(o_led), 32'(m_led));
  endtask

  task automatic drive_cycle(input logic [NREQ-1:0] req, input int hold);
    i_req     = req;
    i_hold    = HOLDW'(hold);
    i_pattern = $urandom;
    i_default = NLEDS'($urandom);
`ifdef LEDARB_PWM_EN
    i_duty    = 8'($urandom);
`endif
    model_step();
    @(posedge i_clk);
    @(negedge i_clk);
    check_outputs();
  endtask

  // Called from a falling edge; reset asserts between edges to show it is asynchronous.
  task automatic pulse_reset();
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_owner", 32'(o_owner), 32'd0);
    chk("rst_led", 32'(o_led), 32'd0);
    model_reset();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    check_outputs();
  endtask

  typedef struct {
    bit              rst;
    logic [NREQ-1:0] req;
    int              hold;
    int              n;
  } step_t;

  step_t plan [9];

  initial begin
    plan = '{
      '{1'b1, 4'b0001,  3,  6},
      '{1'b0, 4'b0000,  0,  2},
      '{1'b0, 4'b0001, 10,  2},
      '{1'b0, 4'b0101, 10, 14},
      '{1'b1, 4'b1111,  0,  8},
      '{1'b1, 4'b0100,  5,  8},
      '{1'b0, 4'b1000,  5,  4},
      '{1'b1, 4'b0001, 20,  5},
      '{1'b1, 4'b0110,  2,  4}
    };
    i_reset_n = 1'b0;
    i_req     = '0;
    i_pattern = '0;
    i_default = '0;
    i_hold    = '0;
`ifdef LEDARB_PWM_EN
    i_duty    = '0;
`endif
    model_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    check_outputs();

    foreach (plan[s]) begin
      if (plan[s].rst) pulse_reset();
      for (int c = 0; c < plan[s].n; c++) drive_cycle(plan[s].req, plan[s].hold);
    end

    begin
      logic [NREQ-1:0] req;
      req = '0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 399) == 0) pulse_reset();
        if ($urandom_range(0, 5) == 0) req = NREQ'($urandom);
        drive_cycle(req, int'($urandom_range(0, 6)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_owner_arb.md
LED_OWNER_ARB -- requirements
Module: led_owner_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of LED-bank requesters (2..8).
REQ-002 Parameter NLEDS, default 8, SHALL set the LED bank width.
REQ-003 Parameter HOLDW, default 16, SHALL set the lease-counter width.
REQ-004 i_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 i_reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 i_req  input  NREQ  SHALL carry per-requester level requests for LED ownership.
REQ-007 i_pattern  input  NREQ*NLEDS  SHALL carry requester k's LED pattern in bits [k*NLEDS +: NLEDS].
REQ-008 i_default  input  NLEDS  SHALL be the pattern driven when no owner exists (e.g. bouncer output).
REQ-009 i_hold  input  HOLDW  SHALL give the minimum lease in clock cycles, sampled at grant.
REQ-010 o_grant  output  NREQ  SHALL be one-hot (or zero) and mark the current owner.
REQ-011 o_owner  output  3  SHALL give the owner index; valid only while o_busy is high.
REQ-012 o_busy  output  1  SHALL be high while any requester owns the bank.
REQ-013 o_led  output  NLEDS  SHALL be the registered LED drive.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, LEASE, OPEN.
REQ-015 In IDLE with i_req nonzero, the block SHALL grant by round-robin starting at (last_owner+1) mod NREQ, assert o_grant on the next cycle, load lease counter with i_hold, and enter LEASE.
REQ-016 In LEASE the counter SHALL decrement once per cycle; on reaching 0 the FSM SHALL enter OPEN; other requests SHALL NOT preempt.
REQ-017 A grant with i_hold=0 SHALL enter OPEN on the cycle after grant.
REQ-018 In LEASE or OPEN, owner dropping i_req SHALL clear o_grant and o_busy on the next cycle and return to IDLE; re-arbitration SHALL then take one further cycle.
REQ-019 In OPEN, any non-owner request SHALL cause direct handover: next cycle o_grant moves to the round-robin winner, counter reloads, state LEASE; no idle cycle.
REQ-020 In OPEN with only the owner requesting, ownership SHALL persist indefinitely.
REQ-021 Owner drop and other-requester arrival in the same cycle SHALL follow REQ-018 (IDLE first).
REQ-022 o_led SHALL equal the owner's i_pattern slice one cycle after sampling when o_busy, else i_default one cycle after sampling.
REQ-023 last_owner SHALL update on every grant; round-robin SHALL wrap NREQ-1 to 0.

Reset
REQ-024 Reset assertion SHALL immediately force IDLE, o_grant=0, o_busy=0, o_owner=0, o_led=0, counter=0, last_owner=NREQ-1 (so requester 0 wins first).
REQ-025 Reset mid-lease SHALL discard the lease; after release, arbitration SHALL restart per REQ-015.

Configuration
REQ-026 Macro LEDARB_PWM_EN, when defined, SHALL add input i_duty[7:0] and a free-running 8-bit counter; o_led SHALL be the REQ-022 value ANDed with (pwm_cnt < i_duty) per bit, registered; duty 0 = always off.
REQ-027 Without LEDARB_PWM_EN, i_duty and the counter SHALL not exist and o_led SHALL follow REQ-022 unchanged.

Structure
REQ-028 Package ledarb_pkg SHALL hold the state enum (IDLE, LEASE, OPEN) and the PWM counter width constant.
REQ-029 Round-robin selection SHALL be a sub-module rr_pick (inputs: request vector, last index; outputs: winner index, valid), purely combinational.

Verification
REQ-030 Reset release, i_req=4'b0001, i_hold=3 -> o_grant=0001 at cycle 1, LEASE for 3 cycles, then OPEN; o_led=pattern0 from cycle 2.
REQ-031 Owner 0 in LEASE (hold=10), i_req=4'b0101 -> no handover until counter 0; then o_grant=0100 on the next cycle.
REQ-032 All four requesting, hold=0, each owner re-requesting -> grants rotate 0,1,2,3,0 with one-cycle OPEN each.
REQ-033 Owner 2 drops i_req while requester 3 raises it same cycle -> one IDLE cycle (o_busy=0, o_led=i_default), then o_grant=1000.
REQ-034 i_reset_n pulsed low mid-LEASE -> outputs zero asynchronously; after release, i_req=4'b0110 grants requester 1.
REQ-035 With LEDARB_PWM_EN, i_duty=64, owner pattern 8'hFF -> o_led high for 64 of every 256 cycles.
